mul_div_unit: RTL and testbench
===============================

MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/HI/LO width (even, >=8).
REQ-002 SHALL have port clk  input  1  rising-edge clock; the block has one clock.
REQ-003 SHALL have port reset  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port start  input  1  request; sampled on the clk rising edge.
REQ-005 SHALL have port funct  input  6  operation code: FUN_MULT, FUN_MULTU, FUN_DIV, FUN_DIVU, FUN_MTHI, FUN_MTLO.
REQ-006 SHALL have ports a, b  input  WIDTH  operand a (rs / dividend), operand b (rt / divisor).
REQ-007 SHALL have port busy  output  1  multi-cycle operation in progress.
REQ-008 SHALL have port done  output  1  one-cycle pulse; hi/lo hold a new result.
REQ-009 SHALL have ports hi, lo  output  WIDTH  architectural HI/LO registers.

Function
REQ-010 SHALL implement FSM states IDLE, CALC, FIX.
- IDLE->CALC on start with a mult/div funct.
- CALC->FIX after exactly WIDTH iterations.
- FIX->IDLE unconditionally.
REQ-011 SHALL sample start in IDLE only; start in CALC/FIX is ignored, including MTHI/MTLO.
REQ-012 SHALL, for a start with an unrecognised funct in IDLE: no state change, no done.
REQ-013 SHALL write hi<=a (MTHI) or lo<=a (MTLO) at the sampling edge, with no busy and no done.
REQ-014 SHALL latch operands at the start edge k; busy high from k+1 through k+WIDTH+1; hi/lo and done update at edge k+WIDTH+2.
REQ-015 SHALL compute MULT/MULTU as a 2*WIDTH-bit product {hi,lo} using a shift-add (1 bit/cycle), signed or unsigned per funct.
REQ-016 SHALL compute DIV/DIVU as restoring division (1 quotient bit/cycle): lo=quotient, hi=remainder.
REQ-017 SHALL, for signed ops, use operand magnitudes in CALC and apply sign correction in FIX: quotient truncates toward zero; remainder takes the dividend's sign.
REQ-018 SHALL return lo=all-ones and hi=a for division by zero (signed or unsigned), with normal latency.
REQ-019 SHALL return lo=a and hi=0 for DIV of most-negative by -1.
REQ-020 SHALL hold hi/lo stable while busy; the old values remain readable until done.
REQ-021 SHALL keep done low whenever busy is high.

Reset
REQ-022 SHALL, on reset: state=IDLE, hi=0, lo=0, busy=0, done=0, internal accumulators cleared.
REQ-023 SHALL abort an in-flight operation when reset is asserted mid-operation, with no done pulse and hi/lo=0.
REQ-024 SHALL give reset priority over start in the same cycle.

Configuration
REQ-025 SHALL support macro MDU_FAST_MULT_EN.
- Defined: MULT/MULTU complete combinationally (single-cycle product), {hi,lo} written at edge k+1, done high at k+1, busy never asserted for multiply.
- Undefined: iterative multiply per REQ-014/015.
- Division is iterative in both builds.

Structure
REQ-026 SHALL take FUN_* funct codes from the shared ISA definitions header; FSM state encodings and MDU constants belong in that same shared header.
REQ-027 SHALL place the restoring-divide datapath (remainder/quotient shift, subtract, restore) in one sub-module, div_core; the FSM, multiply, sign fix and HI/LO stay in mul_div_unit.

Verification (WIDTH=32, MDU_FAST_MULT_EN undefined unless stated)
REQ-028 SHALL cover: MULT a=FFFFFFFF b=00000002 -> done at k+34; hi=FFFFFFFF, lo=FFFFFFFE; MULTU same operands -> hi=00000001, lo=FFFFFFFE.
REQ-029 SHALL cover: DIV a=FFFFFFF9 (-7) b=2 -> lo=FFFFFFFD, hi=FFFFFFFF; DIVU a=7 b=0 -> lo=FFFFFFFF, hi=00000007; DIV a=80000000 b=FFFFFFFF -> lo=80000000, hi=0.
REQ-030 SHALL cover: start DIVU 100/7, then at k+5 start MTHI a=55 -> MTHI ignored; final hi=2, lo=0000000E.
REQ-031 SHALL cover: reset asserted at k+10 of a MULT -> next cycle busy=0, hi=lo=0; no done within 40 cycles.
REQ-032 SHALL cover: MDU_FAST_MULT_EN defined, MULT 3 * FFFFFFFE -> done at k+1, busy never high, hi=FFFFFFFF, lo=FFFFFFFA.
REQ-033 SHALL cover: MTLO a=12345678 in IDLE -> lo=12345678 at next edge, done and busy stay low.

Source files
------------

// File: rtl/mul_div_unit_pkg.sv
// -----------------------------------------------------------------------------
// mul_div_unit_pkg
//   Shared ISA definitions for the multiply/divide unit: SPECIAL-opcode funct
//   codes that address HI/LO, the MDU FSM state encoding, and small decode
//   helpers used by the unit and its testbench.
// -----------------------------------------------------------------------------
package mul_div_unit_pkg;

  // SPECIAL-opcode funct field values handled by the MDU.
  localparam logic [5:0] FUN_MTHI  = 6'h11;
  localparam logic [5:0] FUN_MTLO  = 6'h13;
  localparam logic [5:0] FUN_MULT  = 6'h18;
  localparam logic [5:0] FUN_MULTU = 6'h19;
  localparam logic [5:0] FUN_DIV   = 6'h1A;
  localparam logic [5:0] FUN_DIVU  = 6'h1B;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } mdu_state_e;

  function automatic logic is_mult(input logic [5:0] funct);
    return (funct == FUN_MULT) || (funct == FUN_MULTU);
  endfunction

  function automatic logic is_div(input logic [5:0] funct);
    return (funct == FUN_DIV) || (funct == FUN_DIVU);
  endfunction

  // Signed variants work on magnitudes and need a sign fix afterwards.
  function automatic logic is_signed_op(input logic [5:0] funct);
    return (funct == FUN_MULT) || (funct == FUN_DIV);
  endfunction

endpackage

// File: rtl/mul_div_unit_div_core.sv
// -----------------------------------------------------------------------------
// div_core
//   Unsigned restoring divider, one quotient bit per step.
//   clk, reset            : clock, synchronous active-high reset
//   load                  : capture dividend/divisor, clear remainder
//   step                  : perform one shift/subtract/restore iteration
//   dividend, divisor     : unsigned operands (magnitudes)
//   quotient, remainder   : valid after WIDTH steps following a load
// The quotient register doubles as the dividend shift register: each step the
// top dividend bit moves into the remainder and a quotient bit enters at LSB.
// -----------------------------------------------------------------------------
module div_core #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  logic [WIDTH-1:0] dvsr;
  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff;
  logic             ge;

  // NOTE: always_comb assigns every output on every path, so no latch is inferred.
  always_comb begin
    shifted = {remainder, quotient[WIDTH-1]};
    ge      = (shifted >= {1'b0, dvsr});
    // When ge holds, shifted - dvsr < dvsr, so the low WIDTH bits are exact.
    diff    = shifted[WIDTH-1:0] - dvsr;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      quotient  <= '0;
      remainder <= '0;
      dvsr      <= '0;
    end else if (load) begin
      quotient  <= dividend;
      remainder <= '0;
      dvsr      <= divisor;
    end else if (step) begin
      quotient  <= {quotient[WIDTH-2:0], ge};
      remainder <= ge ? diff : shifted[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/mul_div_unit.sv
// -----------------------------------------------------------------------------
// mul_div_unit
//   MIPS-style multiply/divide unit with architectural HI/LO registers.
//   clk    : rising-edge clock          reset : synchronous, active-high
//   start  : request, sampled in IDLE   funct : FUN_MULT/MULTU/DIV/DIVU/MTHI/MTLO
//   a, b   : rs (dividend), rt (divisor)
//   busy   : multi-cycle operation in progress
//   done   : one-cycle pulse, hi/lo just took a new result
//   hi, lo : HI/LO registers
// Iterative ops: operands latched at start edge k, WIDTH iterations in CALC,
// sign fix in FIX, result committed to hi/lo with done at edge k+WIDTH+2.
// busy/done are registered one edge behind the FSM state.
// Build option: MDU_FAST_MULT_EN -- MULT/MULTU use a single-cycle multiplier,
// committing at edge k+1 with busy never raised. Division stays iterative.
// -----------------------------------------------------------------------------
module mul_div_unit
  import mul_div_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH);

  mdu_state_e       state;
  logic [CNT_W-1:0] cnt;
  logic             op_div;
  logic             neg_q;     // quotient/product must be negated
  logic             neg_r;     // remainder must be negated
  logic             b_zero;
  logic [WIDTH-1:0] a_raw;     // original dividend, returned as hi on /0
  logic [WIDTH-1:0] res_hi;
  logic [WIDTH-1:0] res_lo;
  logic             pending;   // res_* waits for commit on the next edge

  logic             sgn;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] rem;

  always_comb begin
    sgn   = is_signed_op(funct);
    a_mag = (sgn && a[WIDTH-1]) ? -a : a;
    b_mag = (sgn && b[WIDTH-1]) ? -b : b;
  end

`ifdef MDU_FAST_MULT_EN
  logic [2*WIDTH-1:0] mag_prod;
  always_comb mag_prod = {{WIDTH{1'b0}}, a_mag} * {{WIDTH{1'b0}}, b_mag};
`else
  // Shift-add multiply: prod_lo starts as the multiplier and is shifted out
  // LSB-first while partial sums accumulate into prod_hi.
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] prod_hi;
  logic [WIDTH-1:0] prod_lo;
  logic [WIDTH:0]   mult_sum;
  always_comb mult_sum = {1'b0, prod_hi} + (prod_lo[0] ? {1'b0, mcand} : '0);
`endif

  div_core #(.WIDTH(WIDTH)) u_div_core (
    .clk       (clk),
    .reset     (reset),
    .load      ((state == IDLE) && start && is_div(funct)),
    .step      ((state == CALC) && op_div),
    .dividend  (a_mag),
    .divisor   (b_mag),
    .quotient  (quo),
    .remainder (rem)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: datapath registers are reset too, so an aborted operation leaves
      // no stale accumulator contents behind.
      state   <= IDLE;
      cnt     <= '0;
      op_div  <= 1'b0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      b_zero  <= 1'b0;
      a_raw   <= '0;
      res_hi  <= '0;
      res_lo  <= '0;
      pending <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      hi      <= '0;
      lo      <= '0;
`ifndef MDU_FAST_MULT_EN
      mcand   <= '0;
      prod_hi <= '0;
      prod_lo <= '0;
`endif
    end else begin
      busy    <= (state != IDLE);
      done    <= pending;
      pending <= 1'b0;
      if (pending) begin
        hi <= res_hi;
        lo <= res_lo;
      end

      case (state)
        IDLE: begin
          if (start) begin
            // A move issued on the commit edge is the younger write and wins.
            if (funct == FUN_MTHI) begin
              hi <= a;
            end else if (funct == FUN_MTLO) begin
              lo <= a;
            end else if (is_mult(funct)) begin
`ifdef MDU_FAST_MULT_EN
              {res_hi, res_lo} <= (sgn && (a[WIDTH-1] ^ b[WIDTH-1])) ? -mag_prod : mag_prod;
              pending          <= 1'b1;
`else
              state   <= CALC;
              cnt     <= '0;
              op_div  <= 1'b0;
              neg_q   <= sgn && (a[WIDTH-1] ^ b[WIDTH-1]);
              mcand   <= b_mag;
              prod_hi <= '0;
              prod_lo <= a_mag;
`endif
            end else if (is_div(funct)) begin
              state  <= CALC;
              cnt    <= '0;
              op_div <= 1'b1;
              neg_q  <= sgn && (a[WIDTH-1] ^ b[WIDTH-1]);
              neg_r  <= sgn && a[WIDTH-1];
              b_zero <= (b == '0);
              a_raw  <= a;
            end
          end
        end

        CALC: begin
`ifndef MDU_FAST_MULT_EN
          if (!op_div) begin
            {prod_hi, prod_lo} <= {mult_sum, prod_lo[WIDTH-1:1]};
          end
`endif
          cnt <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(WIDTH - 1)) begin
            state <= FIX;
          end
        end

        FIX: begin
          if (op_div) begin
            if (b_zero) begin
              res_lo <= '1;
              res_hi <= a_raw;
            end else begin
              // Negating the magnitude quotient truncates toward zero; the
              // most-negative / -1 case wraps back to the dividend itself.
              res_lo <= neg_q ? -quo : quo;
              res_hi <= neg_r ? -rem : rem;
            end
          end else begin
`ifndef MDU_FAST_MULT_EN
            {res_hi, res_lo} <= neg_q ? -{prod_hi, prod_lo} : {prod_hi, prod_lo};
`endif
          end
          pending <= 1'b1;
          state   <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// -----------------------------------------------------------------------------
// tb_mul_div_unit
//   Self-checking bench for mul_div_unit (WIDTH=32). Directed vector table,
//   hand-written corner sequences (ignored moves, reset abort, reset priority,
//   unknown funct) and randomized operations against a 64-bit arithmetic model.
//   Honours MDU_FAST_MULT_EN for multiply latency expectations.
// -----------------------------------------------------------------------------
module tb_mul_div_unit;
  import mul_div_unit_pkg::*;

  localparam int W = 32;
  localparam int DIV_LAT  = W + 2;
  localparam int DIV_BUSY = W + 1;
`ifdef MDU_FAST_MULT_EN
  localparam int MUL_LAT  = 1;
  localparam int MUL_BUSY = 0;
`else
  localparam int MUL_LAT  = W + 2;
  localparam int MUL_BUSY = W + 1;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [5:0]   funct;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int n_checks = 0;
  int n_err    = 0;

  mul_div_unit #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .funct (funct),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference model: plain 64-bit arithmetic. Returns {hi, lo}.
  function automatic logic [63:0] model(input logic [5:0] f, input logic [31:0] x, input logic [31:0] y);
    longint          sx, sy, sp, sq, sr;
    longint unsigned ux, uy, up, uq, ur;
    logic [63:0]     r;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = {32'h0, x};
    uy = {32'h0, y};
    r  = '0;
    case (f)
      FUN_MULT:  begin sp = sx * sy; r = sp; end
      FUN_MULTU: begin up = ux * uy; r = up; end
      FUN_DIV: begin
        if (y == 32'h0)                               r = {x, 32'hFFFF_FFFF};
        else if (x == 32'h8000_0000 && y == '1)       r = {32'h0, x};
        else begin
          sq = sx / sy;
          sr = sx % sy;
          r  = {sr[31:0], sq[31:0]};
        end
      end
      FUN_DIVU: begin
        if (y == 32'h0) r = {x, 32'hFFFF_FFFF};
        else begin
          uq = ux / uy;
          ur = ux % uy;
          r  = {ur[31:0], uq[31:0]};
        end
      end
      default: r = '0;
    endcase
    return r;
  endfunction

  task automatic do_move(input logic [5:0] f, input logic [31:0] x);
    @(negedge clk);
    start = 1'b1; funct = f; a = x;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Issue one mult/div op and watch it to completion (bounded).
  task automatic run_op(input logic [5:0] f, input logic [31:0] x, input logic [31:0] y,
                        output logic [31:0] rhi, output logic [31:0] rlo,
                        output int lat, output int bcnt, output int bad);
    logic [31:0] h0, l0;
    @(negedge clk);
    h0 = hi; l0 = lo;
    start = 1'b1; funct = f; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0; a = $urandom; b = $urandom;
    lat = -1; bcnt = 0; bad = 0;
    for (int n = 1; n <= 100; n++) begin
      @(posedge clk); #1;
      if (busy) bcnt++;
      if (busy && done) bad++;
      if (!done && (hi !== h0 || lo !== l0)) bad++;
      if (done) begin lat = n; break; end
    end
    rhi = hi; rlo = lo;
  endtask

  task automatic check_op(input string tag, input logic [5:0] f, input logic [31:0] x, input logic [31:0] y,
                          input logic [31:0] ehi, input logic [31:0] elo);
    logic [31:0] rhi, rlo;
    int lat, bcnt, bad;
    run_op(f, x, y, rhi, rlo, lat, bcnt, bad);
    check({tag, " hi"},      rhi, ehi);
    check({tag, " lo"},      rlo, elo);
    check({tag, " latency"}, lat, is_mult(f) ? MUL_LAT : DIV_LAT);
    check({tag, " busy"},    bcnt, is_mult(f) ? MUL_BUSY : DIV_BUSY);
    check({tag, " hold"},    bad, 0);
  endtask

  typedef struct {
    logic [5:0]  f;
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] ehi;
    logic [31:0] elo;
  } vec_t;

  vec_t vecs[11];

  initial begin
    logic [63:0] exp;
    logic [31:0] h0, rx, ry;
    logic [5:0]  rf;
    int          cnt, lat;

    vecs[0]  = '{FUN_MULT,  32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
    vecs[1]  = '{FUN_MULTU, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 32'hFFFF_FFFE};
    vecs[2]  = '{FUN_MULT,  32'h0000_0003, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFA};
    vecs[3]  = '{FUN_MULTU, 32'h0000_0003, 32'hFFFF_FFFE, 32'h0000_0002, 32'hFFFF_FFFA};
    vecs[4]  = '{FUN_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
    vecs[5]  = '{FUN_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[6]  = '{FUN_DIV,   32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
    vecs[7]  = '{FUN_DIVU,  32'h0000_0007, 32'h0000_0000, 32'h0000_0007, 32'hFFFF_FFFF};
    vecs[8]  = '{FUN_DIV,   32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF};
    vecs[9]  = '{FUN_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
    vecs[10] = '{FUN_DIVU,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0000};

    reset = 1'b1; start = 1'b0; funct = '0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset hi",   hi, 0);
    check("reset lo",   lo, 0);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    @(negedge clk);
    reset = 1'b0;

    // MTLO / MTHI write at the sampling edge, with no busy/done.
    do_move(FUN_MTLO, 32'h1234_5678);
    check("mtlo lo",   lo, 32'h1234_5678);
    check("mtlo done", done, 0);
    check("mtlo busy", busy, 0);
    do_move(FUN_MTHI, 32'h0000_00A5);
    check("mthi hi",   hi, 32'h0000_00A5);
    check("mthi lo",   lo, 32'h1234_5678);
    @(posedge clk); #1;
    check("move no done", done, 0);

    // Unrecognised funct: nothing happens.
    do_move(6'h00, 32'hDEAD_BEEF);
    cnt = 0;
    for (int n = 0; n < 4; n++) begin
      if (busy || done || hi !== 32'h0000_00A5 || lo !== 32'h1234_5678) cnt++;
      @(posedge clk); #1;
    end
    check("bad funct ignored", cnt, 0);

    for (int i = 0; i < 11; i++)
      check_op($sformatf("vec%0d", i), vecs[i].f, vecs[i].x, vecs[i].y, vecs[i].ehi, vecs[i].elo);

    // DIVU 100/7 with an MTHI issued at k+5 that must be ignored.
    @(negedge clk);
    h0 = hi;
    start = 1'b1; funct = FUN_DIVU; a = 32'd100; b = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    lat = -1;
    for (int n = 1; n <= 100; n++) begin
      if (n == 5) begin
        @(negedge clk);
        start = 1'b1; funct = FUN_MTHI; a = 32'h55;
      end
      @(posedge clk); #1;
      if (n == 5) begin
        start = 1'b0;
        check("mthi in calc ignored", hi, h0);
      end
      if (done) begin lat = n; break; end
    end
    check("divu mid-mthi latency", lat, DIV_LAT);
    check("divu mid-mthi hi", hi, 32'h2);
    check("divu mid-mthi lo", lo, 32'hE);

    // Reset at k+10 of a multi-cycle op aborts it.
    do_move(FUN_MTHI, 32'hAAAA_AAAA);
    do_move(FUN_MTLO, 32'h5555_5555);
    @(negedge clk);
`ifdef MDU_FAST_MULT_EN
    start = 1'b1; funct = FUN_DIV; a = 32'hFFFF_FFFF; b = 32'h2;
`else
    start = 1'b1; funct = FUN_MULT; a = 32'hFFFF_FFFF; b = 32'h2;
`endif
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    check("abort busy", busy, 0);
    check("abort hi", hi, 0);
    check("abort lo", lo, 0);
    @(negedge clk);
    reset = 1'b0;
    cnt = 0;
    for (int n = 0; n < 40; n++) begin
      @(posedge clk); #1;
      if (done || busy) cnt++;
    end
    check("abort no done", cnt, 0);

    // Reset wins over start in the same cycle.
    do_move(FUN_MTLO, 32'h0000_1111);
    @(negedge clk);
    reset = 1'b1; start = 1'b1; funct = FUN_MTLO; a = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    check("reset priority lo", lo, 0);
    @(negedge clk);
    reset = 1'b0; start = 1'b0;

    // Randomized operations against the model.
    for (int i = 0; i < 30; i++) begin
      case ($urandom_range(0, 3))
        0: rf = FUN_MULT;
        1: rf = FUN_MULTU;
        2: rf = FUN_DIV;
        default: rf = FUN_DIVU;
      endcase
      case ($urandom_range(0, 4))
        0: begin rx = $urandom; ry = $urandom_range(0, 20); end
        1: begin rx = $urandom; ry = 32'h0; end
        2: begin rx = 32'h8000_0000; ry = ($urandom_range(0, 1) == 1) ? 32'hFFFF_FFFF : $urandom; end
        3: begin rx = $urandom_range(0, 1000); ry = -$urandom_range(1, 50); end
        default: begin rx = $urandom; ry = $urandom; end
      endcase
      exp = model(rf, rx, ry);
      check_op($sformatf("rnd%0d f=%h a=%h b=%h", i, rf, rx, ry), rf, rx, ry, exp[63:32], exp[31:0]);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
